// File: rtl/read_arbiter.sv
// read_arbiter
//   Two-master read-address arbiter with per-burst beat tracking.
//   One master at a time owns the read path.
//   - Grant: round-robin on a tie, and M0 wins the first tie after reset.
//   - At grant, the winner's address and length are captured and held until
//     the burst ends.
//   - The slave select is decoded from the captured address.
//   - The owner's R beats are counted against its ARLEN.
//   - A burst-length mismatch raises a one-cycle len_err pulse.
//
// Ports
//   ACLK, ARESET                 clock, async active-high reset
//   ARADDR_Mx/ARVALID_Mx/ARLEN_Mx  read-address request per master
//   ARREADY_S                    address accept from the decoded slave
//   RVALID_Mx/RREADY_Mx/RLAST_Mx   read-data handshake per master port
//   Arbiter_Read_State_control   00 idle, 01 M0 owns bus, 10 M1 owns bus
//   Arbiter_ARID_control         {owner, one-hot slave select}
//   addr_phase                   owner's address waiting for ARREADY_S
//   len_err                      one-cycle pulse on a length mismatch
//
// state | meaning
// IDLE  | no owner; grant on any ARVALID
// ADDR  | owner's address presented, waiting for ARREADY_S
// DATA  | counting owner's R beats until RLAST
module read_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [31:0]      ARADDR_M0,
  input  logic [31:0]      ARADDR_M1,
  input  logic             ARVALID_M0,
  input  logic             ARVALID_M1,
  input  logic [LEN_W-1:0] ARLEN_M0,
  input  logic [LEN_W-1:0] ARLEN_M1,
  input  logic             ARREADY_S,
  input  logic             RVALID_M0,
  input  logic             RVALID_M1,
  input  logic             RREADY_M0,
  input  logic             RREADY_M1,
  input  logic             RLAST_M0,
  input  logic             RLAST_M1,
  output logic [1:0]       Arbiter_Read_State_control,
  output logic [3:0]       Arbiter_ARID_control,
  output logic             addr_phase,
  output logic             len_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;       // 0 = M0, 1 = M1
  logic             r_last_grant;  // master granted most recently
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_len_err;

  logic             w_grant_en;
  logic             w_grant;
  logic             w_load_cnt;
  logic             w_dec_cnt;
  logic             w_err_nxt;
  logic             w_beat;
  logic             w_rlast;
  logic [2:0]       w_slave_sel;

  // Only the owner's R channel counts; the other port is ignored entirely.
  assign w_beat  = r_owner ? (RVALID_M1 & RREADY_M1) : (RVALID_M0 & RREADY_M0);
  assign w_rlast = r_owner ? RLAST_M1 : RLAST_M0;

  assign w_slave_sel = (r_addr[31:17] != 15'd0) ? 3'b100 :
                       (r_addr[16] ? 3'b010 : 3'b001);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_grant     = 1'b0;
    w_load_cnt  = 1'b0;
    w_dec_cnt   = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          w_grant_en  = 1'b1;
          // On a tie, the master not granted last time wins.
          w_grant     = (ARVALID_M0 && ARVALID_M1) ? ~r_last_grant : ARVALID_M1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ARREADY_S) begin
          w_load_cnt  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          if (w_rlast) begin
            w_err_nxt   = (r_cnt != '0);   // early RLAST
            w_state_nxt = S_IDLE;
          end else if (r_cnt == '0) begin
            w_err_nxt   = 1'b1;            // late RLAST, counter saturates at 0
          end else begin
            w_dec_cnt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_len_err <= w_err_nxt;
      if (w_grant_en) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_addr       <= w_grant ? ARADDR_M1 : ARADDR_M0;
        r_len        <= w_grant ? ARLEN_M1 : ARLEN_M0;
      end
      if (w_load_cnt) begin
        r_cnt <= r_len;
      end else if (w_dec_cnt) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign Arbiter_Read_State_control = (r_state == S_IDLE) ? 2'b00 :
                                      (r_owner ? 2'b10 : 2'b01);
  assign Arbiter_ARID_control       = (r_state == S_IDLE) ? 4'b0000 :
                                      {r_owner, w_slave_sel};
  assign addr_phase                 = (r_state == S_ADDR);
  assign len_err                    = r_len_err;

endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter
//   Randomized and directed bursts against a transaction-level model.
//   - The model tracks the round-robin history.
//   - It decodes the slave from the address range.
//   - It predicts len_err from the beat count versus ARLEN + 1.
module tb_read_arbiter;
  localparam int LEN_W = 4;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [31:0]      ARADDR_M0, ARADDR_M1;
  logic             ARVALID_M0, ARVALID_M1;
  logic [LEN_W-1:0] ARLEN_M0, ARLEN_M1;
  logic             ARREADY_S;
  logic             RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1;
  logic [1:0]       Arbiter_Read_State_control;
  logic [3:0]       Arbiter_ARID_control;
  logic             addr_phase;
  logic             len_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_last_m1;   // model: 1 when M1 was the most recent grant

  always #5 ACLK = ~ACLK;

  read_arbiter #(.LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
    .ARREADY_S(ARREADY_S),
    .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
    .RLAST_M0(RLAST_M0), .RLAST_M1(RLAST_M1),
    .Arbiter_Read_State_control(Arbiter_Read_State_control),
    .Arbiter_ARID_control(Arbiter_ARID_control),
    .addr_phase(addr_phase), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] slave_of(input logic [31:0] a);
    if (a < 32'h0001_0000)      return 3'b001;
    else if (a < 32'h0002_0000) return 3'b010;
    else                        return 3'b100;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return $urandom & 32'h0000_FFFF;
      1:       return 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
      default: return $urandom | 32'h0002_0000;
    endcase
  endfunction

  task automatic r_noise();
    RVALID_M0 = 1'($urandom); RREADY_M0 = 1'($urandom); RLAST_M0 = 1'($urandom);
    RVALID_M1 = 1'($urandom); RREADY_M1 = 1'($urandom); RLAST_M1 = 1'($urandom);
  endtask

  task automatic ar_noise();
    ARVALID_M0 = 1'($urandom); ARVALID_M1 = 1'($urandom);
    ARADDR_M0  = rand_addr();  ARADDR_M1  = rand_addr();
    ARLEN_M0   = LEN_W'($urandom); ARLEN_M1 = LEN_W'($urandom);
  endtask

  task automatic quiet();
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0;
    RVALID_M0 = 0; RREADY_M0 = 0; RLAST_M0 = 0;
    RVALID_M1 = 0; RREADY_M1 = 0; RLAST_M1 = 0;
  endtask

  task automatic chk_busy(input string tag, input bit own, input logic [31:0] a, input bit aph);
    chk({tag, "_state"}, 32'(Arbiter_Read_State_control), own ? 32'h2 : 32'h1);
    chk({tag, "_arid"},  32'(Arbiter_ARID_control), 32'({own, slave_of(a)}));
    chk({tag, "_aphase"}, 32'(addr_phase), 32'(aph));
  endtask

  // Drive the owner's R port; the other master's port carries random noise.
  task automatic drive_owner_r(input bit own, input logic v, input logic r, input logic l);
    r_noise();
    if (own) begin RVALID_M1 = v; RREADY_M1 = r; RLAST_M1 = l; end
    else     begin RVALID_M0 = v; RREADY_M0 = r; RLAST_M0 = l; end
  endtask

  // One complete burst, starting and ending at a negedge with the DUT idle.
  // abort_at > 0 asserts reset just before that beat.
  task automatic run_txn(input logic vm0, input logic vm1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                         input int n_beats, input int wait_ar, input int abort_at);
    bit own;
    logic [31:0] ea;
    int el;
    bit exp_err;
    chk("idle_state", 32'(Arbiter_Read_State_control), 0);
    chk("idle_arid",  32'(Arbiter_ARID_control), 0);
    chk("idle_lenerr", 32'(len_err), 0);
    r_noise();
    ARVALID_M0 = vm0; ARVALID_M1 = vm1;
    ARADDR_M0 = a0; ARADDR_M1 = a1; ARLEN_M0 = l0; ARLEN_M1 = l1;
    own = (vm0 && vm1) ? !m_last_m1 : vm1;
    m_last_m1 = own;
    ea = own ? a1 : a0;
    el = int'(own ? l1 : l0);
    @(negedge ACLK);
    for (int i = 0; i < wait_ar; i++) begin
      chk_busy("addr_wait", own, ea, 1);
      chk("addr_lenerr", 32'(len_err), 0);
      ar_noise(); r_noise(); ARREADY_S = 0;
      @(negedge ACLK);
    end
    chk_busy("addr", own, ea, 1);
    ar_noise(); r_noise(); ARREADY_S = 1;
    @(negedge ACLK);
    ARREADY_S = 0;
    chk_busy("data_entry", own, ea, 0);
    for (int k = 1; k <= n_beats; k++) begin
      if (k == abort_at) begin
        #2 ARESET = 1;
        #1;
        chk("rst_state", 32'(Arbiter_Read_State_control), 0);
        chk("rst_arid",  32'(Arbiter_ARID_control), 0);
        chk("rst_aphase", 32'(addr_phase), 0);
        chk("rst_lenerr", 32'(len_err), 0);
        m_last_m1 = 1;
        quiet();
        @(negedge ACLK);
        ARESET = 0;
        return;
      end
      if ($urandom_range(0, 2) == 0) begin
        ar_noise();
        drive_owner_r(own, 1'($urandom), 1'b0, 1'($urandom));
        @(negedge ACLK);
        chk_busy("data_gap", own, ea, 0);
        chk("gap_lenerr", 32'(len_err), 0);
      end
      ar_noise();
      drive_owner_r(own, 1'b1, 1'b1, k == n_beats);
      if (k == n_beats && ARVALID_M0 == 0 && ARVALID_M1 == 0) ARVALID_M1 = 1;
      // Before beat k, k-1 beats have been consumed out of el+1 expected.
      exp_err = (k < n_beats) ? (k > el + 1 - 1) : (n_beats < el + 1);
      @(negedge ACLK);
      chk("beat_lenerr", 32'(len_err), 32'(exp_err));
      if (k < n_beats) chk_busy("beat", own, ea, 0);
      else             chk("bubble_state", 32'(Arbiter_Read_State_control), 0);
    end
    quiet();
    @(negedge ACLK);
    chk("post_state", 32'(Arbiter_Read_State_control), 0);
    chk("post_lenerr", 32'(len_err), 0);
  endtask

  initial begin
    int l;
    quiet();
    ARADDR_M0 = 0; ARADDR_M1 = 0; ARLEN_M0 = 0; ARLEN_M1 = 0;
    ARESET = 1;
    m_last_m1 = 1;
    @(negedge ACLK);
    ARVALID_M0 = 1; ARVALID_M1 = 1;
    @(negedge ACLK);
    chk("inrst_state", 32'(Arbiter_Read_State_control), 0);
    chk("inrst_arid",  32'(Arbiter_ARID_control), 0);
    chk("inrst_aphase", 32'(addr_phase), 0);
    chk("inrst_lenerr", 32'(len_err), 0);
    quiet();
    ARESET = 0;
    @(negedge ACLK);

    // Basic M0 burst of 4 beats to S0.
    run_txn(1, 0, 32'h0000_1000, 0, 3, 0, 4, 1, 0);
    // Tie after reset-equivalent history (last was M0): M1 wins, then M0.
    run_txn(1, 1, 32'h0000_2000, 32'h0001_0004, 1, 2, 3, 0, 0);
    run_txn(1, 1, 32'h0000_2000, 32'h0001_0004, 1, 2, 2, 0, 0);
    run_txn(0, 1, 0, 32'h1000_0000, 0, 0, 1, 2, 0);
    // Early RLAST on beat 2 of a 4-beat burst.
    run_txn(1, 0, 32'h0000_0040, 0, 3, 0, 2, 0, 0);
    // Late RLAST: ARLEN=1, RLAST on beat 3.
    run_txn(0, 1, 0, 32'h0001_FFFC, 0, 1, 3, 1, 0);
    // Reset while counter is 2 (ARLEN=3, one beat consumed).
    run_txn(0, 1, 0, 32'h0000_0100, 0, 3, 4, 0, 2);
    // After reset, the first tie must go to M0.
    run_txn(1, 1, 32'h0001_0004, 32'h0000_0008, 2, 2, 3, 0, 0);

    for (int t = 0; t < 60; t++) begin
      logic v0, v1;
      logic [LEN_W-1:0] l0, l1;
      int lw;
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      l0 = LEN_W'($urandom_range(0, 5)); l1 = LEN_W'($urandom_range(0, 5));
      lw = (v0 && v1) ? int'(m_last_m1 ? l0 : l1) : int'(v1 ? l1 : l0);
      l = $urandom_range(1, lw + 3);
      run_txn(v0, v1, rand_addr(), rand_addr(), l0, l1, l, $urandom_range(0, 2),
              ($urandom_range(0, 9) == 0) ? $urandom_range(1, l) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
